// File: rtl/dot_product_pipe_pkg.sv
// Shared sizing helpers for the dot-product pipeline.
// Default-configuration constants plus width functions used by the top level.
// Pure package: no logic, no state.
package dot_pkg;

  // Ceiling log2 usable in constant expressions; clog2(1) = 0
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Full-precision product width for a given operand width
  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction

  // Adder-tree output width: product plus one carry bit per tree level
  function automatic int sum_w(input int width, input int lanes);
    return prod_w(width) + clog2(lanes);
  endfunction

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_LANES   = 4;
  localparam int TREE_LEVELS = clog2(DEF_LANES);
  localparam int PROD_W      = 2 * DEF_WIDTH;
  localparam int SUM_W       = PROD_W + TREE_LEVELS;

endpackage

// File: rtl/dot_product_pipe_adder_level.sv
// One registered level of the pairwise adder tree: N_IN operands in, N_IN/2 out, 1 bit wider.
// Latency: 1 cycle.
// Backpressure: data, valid and first tag all hold while i_en is low (global stall).
module dot_adder_level #(
  parameter int IN_W   = 64,
  parameter int N_IN   = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_en,
  input  logic                             i_vld,
  input  logic                             i_first,
  input  logic [N_IN*IN_W-1:0]             i_dat,
  output logic                             o_vld,
  output logic                             o_first,
  output logic [(N_IN/2)*(IN_W+1)-1:0]     o_dat
);

  localparam int N_OUT = N_IN / 2;
  localparam int OUT_W = IN_W + 1;

  logic [N_OUT*OUT_W-1:0] w_sum;
  logic [N_OUT*OUT_W-1:0] r_dat;
  logic                   r_vld;
  logic                   r_first;

  // Adjacent operands are paired; each is widened by one bit (sign or zero) before adding
  for (genvar j = 0; j < N_OUT; j++) begin : g_add
    logic [IN_W-1:0] w_l;
    logic [IN_W-1:0] w_r;
    assign w_l = i_dat[(2*j)*IN_W +: IN_W];
    assign w_r = i_dat[(2*j+1)*IN_W +: IN_W];
    assign w_sum[j*OUT_W +: OUT_W] = {SIGNED & w_l[IN_W-1], w_l} + {SIGNED & w_r[IN_W-1], w_r};
  end

  // Level register: advances only with the global pipeline enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld   <= 1'b0;
      r_first <= 1'b0;
      r_dat   <= '0;
    end else if (i_en) begin
      r_vld   <= i_vld;
      r_first <= i_first;
      r_dat   <= w_sum;
    end
  end

  assign o_vld   = r_vld;
  assign o_first = r_first;
  assign o_dat   = r_dat;

endmodule

// File: rtl/dot_product_pipe.sv
// Pipelined LANES-wide dot product with optional cross-beat accumulation (DOT_PRODUCT_PIPE_SAT_EN: saturating add + sat_flag).
// Latency: log2(LANES)+2 cycles from acceptance to out_valid; one beat per cycle.
// Backpressure: whole pipe stalls when out_valid && !out_ready; in_ready = !out_valid || out_ready.
module dot_product_pipe
  import dot_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LANES  = 4,
  parameter bit SIGNED = 1'b0,
  parameter int ACC_W  = 2*WIDTH + clog2(LANES) + 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic                   in_first,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_data,
  output logic                   out_first
`ifdef DOT_PRODUCT_PIPE_SAT_EN
  ,
  output logic                   sat_flag
`endif
);

  localparam int L_TREE   = clog2(LANES);
  localparam int L_PROD_W = prod_w(WIDTH);
  localparam int L_SUM_W  = L_PROD_W + L_TREE;

  logic                      w_adv;
  logic [LANES*L_PROD_W-1:0] w_prod;
  logic [LANES*L_PROD_W-1:0] r_prod;
  logic                      r_s1_vld;
  logic                      r_s1_first;
  logic [L_SUM_W-1:0]        w_sum;
  logic                      w_fin_vld;
  logic                      w_fin_first;
  logic [ACC_W-1:0]          w_acc_nxt;
  logic [ACC_W-1:0]          r_acc;
  logic                      r_out_vld;
  logic                      r_out_first;

  // A stage may move only if the output register is empty or being drained
  assign w_adv    = !r_out_vld || out_ready;
  assign in_ready = w_adv;

  // Lane multipliers; operands are extended to product width so one multiply serves both signednesses
  for (genvar i = 0; i < LANES; i++) begin : g_mul
    logic [WIDTH-1:0]    w_a;
    logic [WIDTH-1:0]    w_b;
    logic [L_PROD_W-1:0] w_ax;
    logic [L_PROD_W-1:0] w_bx;
    assign w_a  = in_a[i*WIDTH +: WIDTH];
    assign w_b  = in_b[i*WIDTH +: WIDTH];
    assign w_ax = {{WIDTH{SIGNED & w_a[WIDTH-1]}}, w_a};
    assign w_bx = {{WIDTH{SIGNED & w_b[WIDTH-1]}}, w_b};
    assign w_prod[i*L_PROD_W +: L_PROD_W] = w_ax * w_bx;
  end

  // S1 product register; a bubble enters as valid = 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_prod     <= '0;
    end else if (w_adv) begin
      r_s1_vld   <= in_valid;
      r_s1_first <= in_first;
      r_prod     <= w_prod;
    end
  end

  // Registered adder tree, each level halving the operand count
  for (genvar k = 0; k < L_TREE; k++) begin : g_lvl
    localparam int IN_W = L_PROD_W + k;
    localparam int N_IN = LANES >> k;
    logic [N_IN*IN_W-1:0]         w_in;
    logic                         w_in_vld;
    logic                         w_in_first;
    logic [(N_IN/2)*(IN_W+1)-1:0] w_out;
    logic                         w_out_vld;
    logic                         w_out_first;

    if (k == 0) begin : g_head
      assign w_in       = r_prod;
      assign w_in_vld   = r_s1_vld;
      assign w_in_first = r_s1_first;
    end else begin : g_link
      assign w_in       = g_lvl[k-1].w_out;
      assign w_in_vld   = g_lvl[k-1].w_out_vld;
      assign w_in_first = g_lvl[k-1].w_out_first;
    end

    dot_adder_level #(
      .IN_W   (IN_W),
      .N_IN   (N_IN),
      .SIGNED (SIGNED)
    ) u_level (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_adv),
      .i_vld   (w_in_vld),
      .i_first (w_in_first),
      .i_dat   (w_in),
      .o_vld   (w_out_vld),
      .o_first (w_out_first),
      .o_dat   (w_out)
    );
  end

  assign w_sum       = g_lvl[L_TREE-1].w_out;
  assign w_fin_vld   = g_lvl[L_TREE-1].w_out_vld;
  assign w_fin_first = g_lvl[L_TREE-1].w_out_first;

`ifdef DOT_PRODUCT_PIPE_SAT_EN
  // Add in a domain two bits wider than both operands so the true result is exact, then clamp
  localparam int L_EXT_W = ((ACC_W > L_SUM_W) ? ACC_W : L_SUM_W) + 2;

  logic [L_EXT_W-1:0] w_sum_x;
  logic [L_EXT_W-1:0] w_acc_x;
  logic [L_EXT_W-1:0] w_tot;
  logic               w_ovf;
  logic               r_sat;

  assign w_sum_x = {{(L_EXT_W-L_SUM_W){SIGNED & w_sum[L_SUM_W-1]}}, w_sum};
  assign w_acc_x = w_fin_first ? '0 : {{(L_EXT_W-ACC_W){SIGNED & r_acc[ACC_W-1]}}, r_acc};
  assign w_tot   = w_acc_x + w_sum_x;

  if (SIGNED) begin : g_sat_s
    // Fits iff every bit from ACC_W-1 upward equals the sign
    logic [L_EXT_W-ACC_W:0] w_hi;
    assign w_hi      = w_tot[L_EXT_W-1:ACC_W-1];
    assign w_ovf     = !((&w_hi) || !(|w_hi));
    assign w_acc_nxt = !w_ovf ? w_tot[ACC_W-1:0] :
                       (w_tot[L_EXT_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}});
  end else begin : g_sat_u
    // Unsigned totals are never negative, so only the top end can be exceeded
    assign w_ovf     = |w_tot[L_EXT_W-1:ACC_W];
    assign w_acc_nxt = w_ovf ? '1 : w_tot[ACC_W-1:0];
  end

  // Sticky clamp indicator, restarted by each new accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat <= 1'b0;
    end else if (w_adv && w_fin_vld) begin
      r_sat <= w_ovf | (r_sat & !w_fin_first);
    end
  end

  assign sat_flag = r_sat;
`else
  // Bring the tree sum to accumulator width; wrap-around discards anything above ACC_W
  logic [ACC_W-1:0] w_sum_a;

  if (ACC_W > L_SUM_W) begin : g_ext
    assign w_sum_a = {{(ACC_W-L_SUM_W){SIGNED & w_sum[L_SUM_W-1]}}, w_sum};
  end else if (ACC_W == L_SUM_W) begin : g_eq
    assign w_sum_a = w_sum;
  end else begin : g_trunc
    assign w_sum_a = w_sum[ACC_W-1:0];
  end

  assign w_acc_nxt = (w_fin_first ? '0 : r_acc) + w_sum_a;
`endif

  // Accumulator/output register; bubbles clear out_valid but leave the accumulator untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_vld   <= 1'b0;
      r_out_first <= 1'b0;
      r_acc       <= '0;
    end else if (w_adv) begin
      r_out_vld <= w_fin_vld;
      if (w_fin_vld) begin
        r_acc       <= w_acc_nxt;
        r_out_first <= w_fin_first;
      end
    end
  end

  assign out_valid = r_out_vld;
  assign out_data  = r_acc;
  assign out_first = r_out_first;

endmodule
